playlist_controller: RTL and testbench

Sequences the song reader through the song ROM's songs. Turns debounced user pulses (play/pause, next, previous) and the reader's `song_done` into the reader's `song` select, `play` level and a one-cycle reader clear. Inserts a programmable silent gap between songs and stops or wraps after the last song. Sits between the button-conditioning logic and the song reader; the note player is untouched.

---
 rtl/playlist_pkg.sv | 14 +
 rtl/gap_timer.sv | 27 ++
 rtl/playlist_controller.sv | 151 +++++++++++++++
 tb/tb_playlist_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/playlist_pkg.sv
// Shared encodings for the playlist controller: FSM states and song-select width.
package playlist_pkg;

  localparam int SONG_W = 2;

  typedef enum logic [2:0] {
    STOPPED = 3'd0,
    LOAD    = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    GAP     = 3'd4
  } state_e;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter that times the silent gap between songs; holds at zero.
module gap_timer #(
  parameter int GAP_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero
);

  logic [GAP_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/playlist_controller.sv
// Playlist sequencer between button conditioning and the song reader.
// Build option: define PLAYLIST_REPEAT_EN to loop back to song 0 after the last song.
module playlist_controller
  import playlist_pkg::*;
#(
  parameter int               NUM_SONGS  = 4,
  parameter int               GAP_W      = 24,
  parameter logic [GAP_W-1:0] GAP_CYCLES = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              song_done,
  output logic [SONG_W-1:0] song,
  output logic              play,
  output logic              reader_clear,
  output logic              playing
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_CYCLES - 1'b1;

  state_e            state;
  state_e            state_nxt;
  logic [SONG_W-1:0] song_nxt;
  logic              song_done_p0;
  logic              song_done_p1;
  logic              done_edge;
  logic              gap_load;
  logic              gap_en;
  logic              gap_zero;

  function automatic logic [SONG_W-1:0] song_advance(input logic [SONG_W-1:0] s);
    return (s == LAST_SONG) ? '0 : s + 1'b1;
  endfunction

  // Retreating from song 0 just restarts it.
  function automatic logic [SONG_W-1:0] song_retreat(input logic [SONG_W-1:0] s);
    return (s == '0) ? '0 : s - 1'b1;
  endfunction

  // Stage p0/p1: registered song_done and its delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song_done_p0 <= 1'b0;
      song_done_p1 <= 1'b0;
    end else begin
      song_done_p0 <= song_done;
      song_done_p1 <= song_done_p0;
    end
  end

  assign done_edge = song_done_p0 & ~song_done_p1;
  assign gap_en    = (state == GAP);

  gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (GAP_LOAD),
    .zero     (gap_zero)
  );

  always_comb begin
    state_nxt = state;
    song_nxt  = song;
    gap_load  = 1'b0;
    case (state)
      STOPPED: begin
        if (play_button) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = PLAY;
      end
      PLAY: begin
        if (play_button) begin
          state_nxt = PAUSE;
        end else if (next_button) begin
          song_nxt  = song_advance(song);
          state_nxt = LOAD;
        end else if (prev_button) begin
          song_nxt  = song_retreat(song);
          state_nxt = LOAD;
        end else if (done_edge) begin
          gap_load  = 1'b1;
          state_nxt = GAP;
        end
      end
      PAUSE: begin
        if (play_button) begin
          state_nxt = PLAY;
        end else if (next_button) begin
          song_nxt  = song_advance(song);
          state_nxt = LOAD;
        end else if (prev_button) begin
          song_nxt  = song_retreat(song);
          state_nxt = LOAD;
        end
      end
      GAP: begin
        if (play_button) begin
          state_nxt = STOPPED;
        end else if (next_button) begin
          song_nxt  = song_advance(song);
          state_nxt = LOAD;
        end else if (prev_button) begin
          song_nxt  = song_retreat(song);
          state_nxt = LOAD;
        end else if (gap_zero) begin
          if (song == LAST_SONG) begin
            song_nxt  = '0;
`ifdef PLAYLIST_REPEAT_EN
            state_nxt = LOAD;
`else
            state_nxt = STOPPED;
`endif
          end else begin
            song_nxt  = song + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: begin
        state_nxt = STOPPED;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= STOPPED;
      song         <= '0;
      play         <= 1'b0;
      playing      <= 1'b0;
      reader_clear <= 1'b0;
    end else begin
      state        <= state_nxt;
      song         <= song_nxt;
      play         <= (state_nxt == PLAY);
      playing      <= (state_nxt == PLAY);
      reader_clear <= (state_nxt == LOAD);
    end
  end

endmodule

// File: tb/tb_playlist_controller.sv
// Directed bench for playlist_controller with an event-level playback model checked every cycle.
module tb_playlist_controller;

  localparam int               NUM_SONGS  = 4;
  localparam int               GAP_W      = 8;
  localparam logic [GAP_W-1:0] GAP_CYCLES = 8'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_button = 1'b0;
  logic       next_button = 1'b0;
  logic       prev_button = 1'b0;
  logic       song_done = 1'b0;
  logic [1:0] song;
  logic       play;
  logic       reader_clear;
  logic       playing;

  int n_pass  = 0;
  int n_total = 0;

  // Playback model: which song, whether a song is selected, pause, pending clear, silent cycles left
  int m_song   = 0;
  bit m_active = 1'b0;
  bit m_paused = 1'b0;
  bit m_clear  = 1'b0;
  int m_gap    = 0;
  bit m_d1     = 1'b0;
  bit m_d2     = 1'b0;

  playlist_controller #(
    .NUM_SONGS  (NUM_SONGS),
    .GAP_W      (GAP_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .prev_button  (prev_button),
    .song_done    (song_done),
    .song         (song),
    .play         (play),
    .reader_clear (reader_clear),
    .playing      (playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic lit(input string nm, input int s, input int p, input int c);
    chk({nm, ".song"}, int'(song), s);
    chk({nm, ".play"}, int'(play), p);
    chk({nm, ".clear"}, int'(reader_clear), c);
  endtask

  task automatic step(input bit pb, input bit nb, input bit vb, input bit sd);
    play_button = pb;
    next_button = nb;
    prev_button = vb;
    song_done   = sd;
    @(posedge clk);
    #1;
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge will see
  always @(negedge clk) begin
    bit edge_seen;
    bit exp_play;
    if (!reset) begin
      m_song = 0; m_active = 0; m_paused = 0; m_clear = 0; m_gap = 0; m_d1 = 0; m_d2 = 0;
    end
    exp_play = m_active && !m_clear && !m_paused && (m_gap == 0);
    chk("model.song", int'(song), m_song);
    chk("model.play", int'(play), int'(exp_play));
    chk("model.playing", int'(playing), int'(exp_play));
    chk("model.clear", int'(reader_clear), int'(m_clear));
    if (reset) begin
      edge_seen = m_d1 && !m_d2;
      m_d2 = m_d1;
      m_d1 = song_done;
      if (m_clear) begin
        m_clear = 0;
      end else if (!m_active) begin
        if (play_button) begin m_active = 1; m_clear = 1; m_paused = 0; end
      end else if (m_gap > 0) begin
        if (play_button) begin
          m_active = 0; m_gap = 0;
        end else if (next_button) begin
          m_song = (m_song + 1) % NUM_SONGS; m_gap = 0; m_clear = 1;
        end else if (prev_button) begin
          m_song = (m_song > 0) ? m_song - 1 : 0; m_gap = 0; m_clear = 1;
        end else if (m_gap == 1) begin
          m_gap = 0;
          if (m_song == NUM_SONGS - 1) begin
            m_song = 0;
`ifdef PLAYLIST_REPEAT_EN
            m_clear = 1;
`else
            m_active = 0;
`endif
          end else begin
            m_song = m_song + 1; m_clear = 1;
          end
        end else begin
          m_gap = m_gap - 1;
        end
      end else if (m_paused) begin
        if (play_button) m_paused = 0;
        else if (next_button) begin m_song = (m_song + 1) % NUM_SONGS; m_paused = 0; m_clear = 1; end
        else if (prev_button) begin m_song = (m_song > 0) ? m_song - 1 : 0; m_paused = 0; m_clear = 1; end
      end else begin
        if (play_button) m_paused = 1;
        else if (next_button) begin m_song = (m_song + 1) % NUM_SONGS; m_clear = 1; end
        else if (prev_button) begin m_song = (m_song > 0) ? m_song - 1 : 0; m_clear = 1; end
        else if (edge_seen) m_gap = int'(GAP_CYCLES);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int silent;
    int clears;
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 0, 0, 0);
    chk("reset.playing", int'(playing), 0);
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    step(1, 0, 0, 0); lit("start_clear", 0, 0, 1);
    step(0, 0, 0, 0); lit("start_play", 0, 1, 0);
    chk("start.playing", int'(playing), 1);
    step(0, 1, 0, 0); lit("next_clear", 1, 0, 1);
    step(0, 0, 0, 0); lit("song1_play", 1, 1, 0);

    // song_done held high through the gap and into the next song
    step(0, 0, 0, 1); lit("done_seen", 1, 1, 0);
    step(0, 0, 0, 1); lit("gap_start", 1, 0, 0);
    silent = 1; clears = 0; cyc = 0;
    while (play !== 1'b1 && cyc < 40) begin
      step(0, 0, 0, 1);
      if (reader_clear) clears++;
      else if (!play) silent++;
      cyc++;
    end
    chk("gap_silent", silent, 5);
    chk("gap_clears", clears, 1);
    lit("song2_play", 2, 1, 0);
    repeat (3) step(0, 0, 0, 1);
    lit("no_retrigger", 2, 1, 0);
    step(0, 0, 0, 0);

    step(0, 1, 0, 0); step(0, 0, 0, 0); lit("song3_play", 3, 1, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 0); lit("last_gap", 3, 0, 0);
    clears = 0;
    repeat (10) begin
      step(0, 0, 0, 0);
      if (reader_clear) clears++;
    end
`ifdef PLAYLIST_REPEAT_EN
    lit("wrap_repeat", 0, 1, 0);
    chk("wrap_repeat.clears", clears, 1);
`else
    lit("wrap_stop", 0, 0, 0);
    chk("wrap_stop.clears", clears, 0);
    step(1, 0, 0, 0); lit("restart_clear", 0, 0, 1);
    step(0, 0, 0, 0); lit("restart_play", 0, 1, 0);
`endif

    step(0, 0, 1, 0); lit("prev0_clear", 0, 0, 1);
    step(0, 0, 0, 0); lit("prev0_play", 0, 1, 0);
    repeat (3) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    lit("song3_again", 3, 1, 0);
    step(0, 1, 1, 0); lit("next_prev_wrap", 0, 0, 1);
    step(0, 0, 0, 0);

    step(1, 1, 0, 0); lit("pause_wins", 0, 0, 0);
    chk("pause.playing", int'(playing), 0);
    step(1, 0, 0, 0); lit("resume", 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); lit("pause_next", 1, 0, 1);
    step(0, 0, 0, 0); lit("song1_again", 1, 1, 0);

    step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0); lit("gap_mid", 1, 0, 0);
    step(1, 0, 0, 0); lit("gap_stop", 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    lit("stopped_hold", 1, 0, 0);
    step(1, 0, 0, 0); lit("stop_restart", 1, 0, 1);
    step(0, 0, 0, 0); lit("stop_restart_play", 1, 1, 0);

    step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 1, 0, 0); lit("gap_next", 2, 0, 1);
    step(0, 0, 0, 0); lit("gap_next_play", 2, 1, 0);

    step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0); lit("pre_reset", 2, 0, 0);
    #2 reset = 1'b0;
    #1 lit("async_reset_gap", 0, 0, 0);
    chk("async_reset_gap.playing", int'(playing), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 0, 0, 0); lit("post_reset_clear", 0, 0, 1);
    step(0, 0, 0, 0); lit("post_reset_play", 0, 1, 0);

    #2 reset = 1'b0;
    #1 lit("async_reset_play", 0, 0, 0);
    chk("async_reset_play.playing", int'(playing), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); lit("idle_after_reset", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
